ghash_ctrl: RTL

GHASH_CTRL -- requirements
Module: ghash_ctrl

---
 rtl/ghash_pkg.sv | 63 ++++++
 rtl/ghash_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/ghash_pkg.sv
// Shared definitions for the GHASH controller: FSM states, datapath mux
// encodings and the registered control-output bundle.
package ghash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_H = 3'd1,
        ST_CLEAR  = 3'd2,
        ST_AAD    = 3'd3,
        ST_CT     = 3'd4,
        ST_LEN    = 3'd5,
        ST_MWAIT  = 3'd6,
        ST_FIN    = 3'd7
    } state_t;

    localparam logic [1:0] MUX_AAD = 2'b00;
    localparam logic [1:0] MUX_CT  = 2'b01;
    localparam logic [1:0] MUX_LEN = 2'b10;

    // Registered control outputs; len_en is the LEN-phase accumulator strobe.
    typedef struct packed {
        logic       h_reg_en;
        logic       ac_clr;
        logic [1:0] mux_sel;
        logic       blk_ready;
        logic       len_en;
        logic       s_reg_en;
        logic       done;
        logic       busy;
    } ctrl_out_t;

    // First phase, in AAD/CT/LEN order, that still has work.
    function automatic state_t next_phase(input logic aad_more, input logic ct_more);
        if (aad_more) begin
            return ST_AAD;
        end
        if (ct_more) begin
            return ST_CT;
        end
        return ST_LEN;
    endfunction

    // Output values to present while in state s; mux_hold keeps the current
    // select in states that do not drive one of their own.
    function automatic ctrl_out_t decode_out(input state_t s, input logic [1:0] mux_hold);
        ctrl_out_t o;
        o         = '0;
        o.mux_sel = mux_hold;
        case (s)
            ST_IDLE:   o.mux_sel = MUX_AAD;
            ST_LOAD_H: begin o.h_reg_en = 1'b1; o.busy = 1'b1; end
            ST_CLEAR:  begin o.ac_clr = 1'b1; o.busy = 1'b1; end
            ST_AAD:    begin o.mux_sel = MUX_AAD; o.blk_ready = 1'b1; o.busy = 1'b1; end
            ST_CT:     begin o.mux_sel = MUX_CT; o.blk_ready = 1'b1; o.busy = 1'b1; end
            ST_LEN:    begin o.mux_sel = MUX_LEN; o.len_en = 1'b1; o.busy = 1'b1; end
            ST_MWAIT:  o.busy = 1'b1;
            ST_FIN:    begin o.s_reg_en = 1'b1; o.done = 1'b1; end
            default:   o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/ghash_ctrl.sv
// GHASH sequencing controller: loads H, clears the accumulator, feeds AAD,
// ciphertext and length blocks with optional multiplier wait cycles, then
// captures S and pulses done.
module ghash_ctrl
    import ghash_pkg::*;
#(
    parameter int unsigned WIDTH    = 128,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned MULT_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] aad_blocks,
    input  logic [CNT_W-1:0] ct_blocks,
    input  logic             blk_valid,
    output logic             blk_ready,
    output logic             h_reg_en,
    output logic             ac_clr,
    output logic [1:0]       mux_sel,
    output logic             ac_reg_en,
    output logic             s_reg_en,
    output logic             busy,
    output logic             done
);

    // Block type of the controlled datapath, kept here for integrators.
    typedef logic [WIDTH-1:0] block_t;

    localparam int unsigned WAIT_W    = 4;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MULT_LAT - 1);

    state_t            state;
    state_t            ret_state;
    state_t            after_upd;
    state_t            after_clear;
    logic [CNT_W-1:0]  aad_cnt;
    logic [CNT_W-1:0]  ct_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    ctrl_out_t         outs;

    // Phase to enter after the current accumulator update or after CLEAR.
    assign after_upd   = (state == ST_AAD) ? next_phase(aad_cnt != CNT_W'(1), ct_cnt != '0) :
                         (state == ST_CT)  ? next_phase(1'b0, ct_cnt != CNT_W'(1)) :
                                             ST_FIN;
    assign after_clear = next_phase(aad_cnt != '0, ct_cnt != '0);

    // Accumulator strobe: same-cycle on a block transfer, or the LEN update.
    assign ac_reg_en = (outs.blk_ready & blk_valid) | outs.len_en;

    assign blk_ready = outs.blk_ready;
    assign h_reg_en  = outs.h_reg_en;
    assign ac_clr    = outs.ac_clr;
    assign mux_sel   = outs.mux_sel;
    assign s_reg_en  = outs.s_reg_en;
    assign busy      = outs.busy;
    assign done      = outs.done;

    // Controller FSM with block counters, wait counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ret_state <= ST_IDLE;
            aad_cnt   <= '0;
            ct_cnt    <= '0;
            wait_cnt  <= '0;
            outs      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        aad_cnt <= aad_blocks;
                        ct_cnt  <= ct_blocks;
                        state   <= ST_LOAD_H;
                        outs    <= decode_out(ST_LOAD_H, MUX_AAD);
                    end
                end
                ST_LOAD_H: begin
                    state <= ST_CLEAR;
                    outs  <= decode_out(ST_CLEAR, outs.mux_sel);
                end
                ST_CLEAR: begin
                    state <= after_clear;
                    outs  <= decode_out(after_clear, outs.mux_sel);
                end
                ST_AAD, ST_CT, ST_LEN: begin
                    if (ac_reg_en) begin
                        if (state == ST_AAD) begin
                            aad_cnt <= aad_cnt - CNT_W'(1);
                        end
                        if (state == ST_CT) begin
                            ct_cnt <= ct_cnt - CNT_W'(1);
                        end
                        if (MULT_LAT != 0) begin
                            state     <= ST_MWAIT;
                            ret_state <= after_upd;
                            wait_cnt  <= WAIT_INIT;
                            outs      <= decode_out(ST_MWAIT, outs.mux_sel);
                        end else begin
                            state <= after_upd;
                            outs  <= decode_out(after_upd, outs.mux_sel);
                        end
                    end
                end
                ST_MWAIT: begin
                    if (wait_cnt == '0) begin
                        state <= ret_state;
                        outs  <= decode_out(ret_state, outs.mux_sel);
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                    outs  <= decode_out(ST_IDLE, MUX_AAD);
                end
                default: begin
                    state <= ST_IDLE;
                    outs  <= '0;
                end
            endcase
        end
    end

endmodule
